ship_board: RTL and testbench

SHIP_BOARD -- requirements
Module: ship_board

---
 rtl/ship_board_if.sv | 64 ++++++
 rtl/ship_board.sv | 210 +++++++++++++++++++++
 tb/tb_ship_board.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ship_board_if.sv
// ship_board_if -- bundle of the ship_board control, handshake and display
// signals. clk/rst are not part of the bundle.
//   slave  : view used by ship_board (requests in, responses/status out)
//   master : view used by whatever drives the board
// Optional macro SHIP_BOARD_FOG_EN adds the rd_fog display input.
interface ship_board_if #(
  parameter int BOARD_W   = 10,
  parameter int BOARD_H   = 10,
  parameter int MAX_SHIPS = 10
);
  localparam int XW = $clog2(BOARD_W);
  localparam int YW = $clog2(BOARD_H);
  localparam int CW = $clog2(MAX_SHIPS + 1);

  logic          clear_req;
  logic          busy;
  logic          place_valid;
  logic          place_ready;
  logic [XW-1:0] place_x;
  logic [YW-1:0] place_y;
  logic          place_ok;
  logic          place_err;
  logic          shot_valid;
  logic          shot_ready;
  logic [XW-1:0] shot_x;
  logic [YW-1:0] shot_y;
  logic          shot_resp_valid;
  logic [1:0]    shot_resp;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic [1:0]    rd_code;
  logic [CW-1:0] ship_count;
  logic [CW-1:0] hits_left;
  logic          all_sunk;
`ifdef SHIP_BOARD_FOG_EN
  logic          rd_fog;

  modport slave (
    input  clear_req, place_valid, place_x, place_y, shot_valid, shot_x, shot_y,
           rd_x, rd_y, rd_fog,
    output busy, place_ready, place_ok, place_err, shot_ready, shot_resp_valid,
           shot_resp, rd_code, ship_count, hits_left, all_sunk
  );
  modport master (
    output clear_req, place_valid, place_x, place_y, shot_valid, shot_x, shot_y,
           rd_x, rd_y, rd_fog,
    input  busy, place_ready, place_ok, place_err, shot_ready, shot_resp_valid,
           shot_resp, rd_code, ship_count, hits_left, all_sunk
  );
`else
  modport slave (
    input  clear_req, place_valid, place_x, place_y, shot_valid, shot_x, shot_y,
           rd_x, rd_y,
    output busy, place_ready, place_ok, place_err, shot_ready, shot_resp_valid,
           shot_resp, rd_code, ship_count, hits_left, all_sunk
  );
  modport master (
    output clear_req, place_valid, place_x, place_y, shot_valid, shot_x, shot_y,
           rd_x, rd_y,
    input  busy, place_ready, place_ok, place_err, shot_ready, shot_resp_valid,
           shot_resp, rd_code, ship_count, hits_left, all_sunk
  );
`endif
endinterface

// File: rtl/ship_board.sv
// ship_board -- battleship board: cell storage, ship placement, shot
// resolution and a registered display read port.
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   bus        ship_board_if.slave: clear_req/busy, place_* handshake and
//              ok/err pulses, shot_* handshake and response, rd_x/rd_y ->
//              rd_code, ship_count, hits_left, all_sunk
// Cell codes: 00 empty, 01 ship, 10 missed, 11 hit.
// Optional macro SHIP_BOARD_FOG_EN: adds bus.rd_fog; when set, ship cells
// read back as empty on rd_code.
module ship_board #(
  parameter int BOARD_W   = 10,
  parameter int BOARD_H   = 10,
  parameter int MAX_SHIPS = 10
) (
  input  logic         clk,
  input  logic         rst,
  ship_board_if.slave  bus
);
  localparam int XW = $clog2(BOARD_W);
  localparam int YW = $clog2(BOARD_H);
  localparam int CW = $clog2(MAX_SHIPS + 1);
  localparam int N  = BOARD_W * BOARD_H;
  localparam int AW = $clog2(N);

  localparam logic [1:0] C_EMPTY = 2'b00;
  localparam logic [1:0] C_SHIP  = 2'b01;
  localparam logic [1:0] C_MISS  = 2'b10;
  localparam logic [1:0] C_HIT   = 2'b11;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] left_q, left_d;
  logic [1:0]    rd_code_q, rd_code_d;
  logic [1:0]    resp_q, resp_d;
  logic          resp_vld_q, resp_vld_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;

  // Board storage has no reset: only the sweep clears it.
  logic [1:0]    board_q [N];
  logic          we;
  logic [AW-1:0] waddr;
  logic [1:0]    wdata;

  logic          sweep_last;
  logic          busy, shot_ready, place_ready;
  logic          shot_acc, place_acc;

  logic          place_in, shot_in, rd_in;
  logic [AW-1:0] place_addr, shot_addr, rd_addr;
  logic [1:0]    place_cell, shot_cell, rd_raw;

  // Coordinates are wider than the board when the dimension is not a power
  // of two; out-of-range cells never index storage.
  always_comb begin
    place_in   = (int'(bus.place_x) < BOARD_W) && (int'(bus.place_y) < BOARD_H);
    shot_in    = (int'(bus.shot_x)  < BOARD_W) && (int'(bus.shot_y)  < BOARD_H);
    rd_in      = (int'(bus.rd_x)    < BOARD_W) && (int'(bus.rd_y)    < BOARD_H);
    place_addr = AW'(int'(bus.place_y) * BOARD_W + int'(bus.place_x));
    shot_addr  = AW'(int'(bus.shot_y)  * BOARD_W + int'(bus.shot_x));
    rd_addr    = AW'(int'(bus.rd_y)    * BOARD_W + int'(bus.rd_x));
    place_cell = place_in ? board_q[place_addr] : C_HIT;
    shot_cell  = shot_in  ? board_q[shot_addr]  : C_HIT;
    rd_raw     = rd_in    ? board_q[rd_addr]    : C_EMPTY;
  end

  assign sweep_last = (idx_q == AW'(N - 1));

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_CLEAR;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: if (sweep_last) state_d = S_IDLE;
      S_IDLE: begin
        if (bus.clear_req)            state_d = S_CLEAR;
        else if (shot_acc || place_acc) state_d = S_RESP;
      end
      S_RESP:  state_d = bus.clear_req ? S_CLEAR : S_IDLE;
      default: state_d = S_CLEAR;
    endcase
  end

  // FSM: outputs. Shots win over placements when both are offered.
  always_comb begin
    busy        = (state_q == S_CLEAR);
    shot_ready  = (state_q == S_IDLE) && !bus.clear_req;
    place_ready = (state_q == S_IDLE) && !bus.clear_req && !bus.shot_valid;
  end

  assign shot_acc  = shot_ready  && bus.shot_valid;
  assign place_acc = place_ready && bus.place_valid;

  // Datapath: storage writes, counters and result registers.
  always_comb begin
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    left_d     = left_q;
    resp_d     = resp_q;
    resp_vld_d = 1'b0;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    we         = 1'b0;
    waddr      = idx_q;
    wdata      = C_EMPTY;
    if (state_q == S_CLEAR) begin
      we    = 1'b1;
      idx_d = sweep_last ? '0 : idx_q + AW'(1);
    end else if (bus.clear_req) begin
      // Restart the sweep from cell 0; counters drop at once.
      cnt_d  = '0;
      left_d = '0;
      idx_d  = '0;
    end else if (shot_acc) begin
      resp_vld_d = 1'b1;
      if (!shot_in) begin
        resp_d = 2'b11;
      end else begin
        case (shot_cell)
          C_EMPTY: begin
            we     = 1'b1;
            waddr  = shot_addr;
            wdata  = C_MISS;
            resp_d = 2'b00;
          end
          C_SHIP: begin
            we     = 1'b1;
            waddr  = shot_addr;
            wdata  = C_HIT;
            resp_d = 2'b01;
            if (left_q != '0) left_d = left_q - CW'(1);
          end
          default: resp_d = 2'b10;
        endcase
      end
    end else if (place_acc) begin
      if (place_in && (place_cell == C_EMPTY) && (cnt_q < CW'(MAX_SHIPS))) begin
        ok_d  = 1'b1;
        we    = 1'b1;
        waddr = place_addr;
        wdata = C_SHIP;
        cnt_d = cnt_q + CW'(1);
        if (left_q < CW'(MAX_SHIPS)) left_d = left_q + CW'(1);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Display read runs in every state, including during the sweep.
  always_comb begin
    rd_code_d = rd_raw;
`ifdef SHIP_BOARD_FOG_EN
    if (bus.rd_fog && (rd_raw == C_SHIP)) rd_code_d = C_EMPTY;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      cnt_q      <= '0;
      left_q     <= '0;
      rd_code_q  <= 2'b00;
      resp_q     <= 2'b00;
      resp_vld_q <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      left_q     <= left_d;
      rd_code_q  <= rd_code_d;
      resp_q     <= resp_d;
      resp_vld_q <= resp_vld_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) board_q[waddr] <= wdata;
  end

  assign bus.busy            = busy;
  assign bus.shot_ready      = shot_ready;
  assign bus.place_ready     = place_ready;
  assign bus.place_ok        = ok_q;
  assign bus.place_err       = err_q;
  assign bus.shot_resp_valid = resp_vld_q;
  assign bus.shot_resp       = resp_q;
  assign bus.rd_code         = rd_code_q;
  assign bus.ship_count      = cnt_q;
  assign bus.hits_left       = left_q;
  assign bus.all_sunk        = (cnt_q != '0) && (left_q == '0);

endmodule

// File: tb/tb_ship_board.sv
// tb_ship_board -- directed plus randomized checks of ship_board against a
// cell-array reference model held in the bench.
module tb_ship_board;
  localparam int W   = 10;
  localparam int H   = 10;
  localparam int MAX = 10;
  localparam int N   = W * H;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ship_board_if #(.BOARD_W(W), .BOARD_H(H), .MAX_SHIPS(MAX)) bus ();
  ship_board #(.BOARD_W(W), .BOARD_H(H), .MAX_SHIPS(MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int mdl [N];
  int m_cnt, m_left;
  bit fog = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input int x, input int y);
    return (x < W) && (y < H);
  endfunction

  function automatic int model_rd(input int x, input int y);
    int c;
    if (!in_rng(x, y)) return 0;
    c = mdl[y*W + x];
    if (fog && c == 1) c = 0;
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) mdl[i] = 0;
    m_cnt  = 0;
    m_left = 0;
  endtask

  // Counts cycles until busy drops; clear_req is held through the first
  // few cycles to show it cannot restart a sweep in progress.
  task automatic sweep();
    int n = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (n >= 4) bus.clear_req = 1'b0;
      if (n == 50) chk("sweep_ready", {bus.shot_ready, bus.place_ready}, 0);
      if (!bus.busy) break;
    end
    chk("sweep_len", n, N);
    chk("post_sweep_ready", bus.shot_ready, 1);
    model_clear();
    chk("post_sweep_count", bus.ship_count, 0);
    chk("post_sweep_left", bus.hits_left, 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.shot_ready === 1'b1) break;
    end
    chk("idle_ready", bus.shot_ready, 1);
  endtask

  task automatic do_clear();
    wait_idle();
    bus.clear_req = 1'b1;
    @(posedge clk);
    sweep();
  endtask

  task automatic do_read(input int x, input int y);
    @(negedge clk);
    bus.rd_x = 4'(x);
    bus.rd_y = 4'(y);
    @(negedge clk);
    chk($sformatf("rd(%0d,%0d)", x, y), bus.rd_code, model_rd(x, y));
  endtask

  task automatic do_place(input int x, input int y);
    bit ok;
    wait_idle();
    bus.place_x = 4'(x);
    bus.place_y = 4'(y);
    bus.place_valid = 1'b1;
    #1;
    chk("place_ready", bus.place_ready, 1);
    @(posedge clk);
    ok = in_rng(x, y) && (m_cnt < MAX);
    if (ok) ok = (mdl[y*W + x] == 0);
    if (ok) begin
      mdl[y*W + x] = 1;
      m_cnt++;
      m_left++;
    end
    #1 bus.place_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("place_ok(%0d,%0d)", x, y), bus.place_ok, ok);
    chk($sformatf("place_err(%0d,%0d)", x, y), bus.place_err, !ok);
    chk("ship_count", bus.ship_count, m_cnt);
    chk("hits_left", bus.hits_left, m_left);
    chk("resp_ready", {bus.shot_ready, bus.place_ready}, 0);
    @(negedge clk);
    chk("b2b_ready", bus.place_ready, 1);
  endtask

  task automatic do_shot(input int x, input int y);
    int r;
    wait_idle();
    bus.shot_x = 4'(x);
    bus.shot_y = 4'(y);
    bus.shot_valid = 1'b1;
    #1;
    chk("shot_ready", bus.shot_ready, 1);
    @(posedge clk);
    if (!in_rng(x, y)) r = 3;
    else begin
      case (mdl[y*W + x])
        0: begin mdl[y*W + x] = 2; r = 0; end
        1: begin mdl[y*W + x] = 3; r = 1; if (m_left > 0) m_left--; end
        default: r = 2;
      endcase
    end
    #1 bus.shot_valid = 1'b0;
    @(negedge clk);
    chk("shot_resp_valid", bus.shot_resp_valid, 1);
    chk($sformatf("shot_resp(%0d,%0d)", x, y), bus.shot_resp, r);
    chk("hits_left", bus.hits_left, m_left);
    chk("all_sunk", bus.all_sunk, (m_cnt != 0) && (m_left == 0));
    chk("resp_ready", {bus.shot_ready, bus.place_ready}, 0);
    @(negedge clk);
    chk("b2b_ready", bus.shot_ready, 1);
    chk("pulse_clr", bus.shot_resp_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.clear_req = 1'b0;
    bus.place_valid = 1'b0;
    bus.place_x = '0;
    bus.place_y = '0;
    bus.shot_valid = 1'b0;
    bus.shot_x = '0;
    bus.shot_y = '0;
    bus.rd_x = '0;
    bus.rd_y = '0;
`ifdef SHIP_BOARD_FOG_EN
    bus.rd_fog = 1'b0;
`endif
    model_clear();

    // Reset state
    #12;
    chk("rst_busy", bus.busy, 1);
    chk("rst_ready", {bus.shot_ready, bus.place_ready}, 0);
    chk("rst_count", bus.ship_count, 0);
    chk("rst_left", bus.hits_left, 0);
    chk("rst_rd", bus.rd_code, 0);
    chk("rst_resp", {bus.shot_resp_valid, bus.shot_resp}, 0);
    chk("rst_pulses", {bus.place_ok, bus.place_err}, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    sweep();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) do_read(x, y);
    do_read(15, 3);

    // Duplicate placement
    do_place(3, 4);
    do_place(3, 4);
    do_read(3, 4);

    // Capacity limit
    do_clear();
    for (int i = 0; i < 10; i++) do_place(i, 7);
    do_place(2, 2);
    chk("cap_count", bus.ship_count, MAX);
    do_read(2, 2);

    // Hit / repeat / miss / out-of-range
    do_clear();
    do_place(0, 0);
    do_shot(0, 0);
    do_shot(0, 0);
    do_shot(1, 1);
    do_shot(12, 0);
    do_read(0, 0);
    do_read(1, 1);

    // Shot has priority over a same-cycle placement
    do_clear();
    do_place(5, 5);
    wait_idle();
    bus.shot_x = 4'd5;
    bus.shot_y = 4'd5;
    bus.place_x = 4'd6;
    bus.place_y = 4'd6;
    bus.shot_valid = 1'b1;
    bus.place_valid = 1'b1;
    #1;
    chk("prio_place_ready", bus.place_ready, 0);
    chk("prio_shot_ready", bus.shot_ready, 1);
    @(posedge clk);
    mdl[5*W + 5] = 3;
    m_left--;
    #1;
    bus.shot_valid = 1'b0;
    bus.place_valid = 1'b0;
    @(negedge clk);
    chk("prio_resp", {bus.shot_resp_valid, bus.shot_resp}, 3'b101);
    chk("prio_no_place", {bus.place_ok, bus.place_err}, 0);
    chk("prio_sunk", bus.all_sunk, 1);
    chk("prio_count", bus.ship_count, 1);
    do_read(6, 6);
    do_read(5, 5);

    // Randomized mix against the model, with occasional clears
    for (int k = 0; k < 250; k++) begin
      int x, y, op;
      x  = $urandom_range(0, 11);
      y  = $urandom_range(0, 11);
      op = $urandom_range(0, 19);
      if (op == 0 && k > 200) do_clear();
      else if (op < 9) do_place(x, y);
      else if (op < 17) do_shot(x, y);
      else do_read(x, y);
    end

    // Clear mid-game, then the whole board must read empty
    do_clear();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) do_read(x, y);

`ifdef SHIP_BOARD_FOG_EN
    do_place(4, 4);
    fog = 1'b1;
    bus.rd_fog = 1'b1;
    do_read(4, 4);
    fog = 1'b0;
    bus.rd_fog = 1'b0;
    do_read(4, 4);
`endif

    // Asynchronous reset between clock edges
    do_place(2, 2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_count", bus.ship_count, 0);
    chk("async_left", bus.hits_left, 0);
    chk("async_busy", bus.busy, 1);
    #1 rst = 1'b0;
    sweep();
    do_read(2, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
